disp_wta_stream: RTL and testbench
==================================

# disp_wta_stream

Streaming winner-takes-all disparity selector that succeeds the single-pair combinational disparity comparator. It accepts the D matching costs of one pixel over D/P beats, P costs per beat, and reduces them to the best disparity, best cost, second-best cost and a uniqueness flag. It sits between the cost-aggregation stage and the disparity-refinement/output stage, with valid/ready handshakes on both sides.

## Interface
- WC, 3: census window side; sets cost width together with WH.
- WH, 7: aggregation window side.
- D, 64: disparity candidates per pixel; D ≥ 2.
- P, 4: costs per input beat; power of 2; D % P == 0.
- UTH, 2: minimum (second − best) margin for a unique match.
- Derived: DBIT = $clog2(D); CBIT = $clog2(((WC**2)/2)*(WH**2)); NB = D/P beats per pixel.
- Clock/reset: one clock; reset is asynchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts a beat this cycle.
- i_cost  in  P*CBIT  lane k (bits k*CBIT +: CBIT) = cost of disparity beat*P + k.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_disp  out  DBIT  disparity of minimum cost.
- o_cost  out  CBIT  minimum cost.
- o_second  out  CBIT  second-smallest cost over all D (may equal o_cost).
- o_unique  out  1  (o_second − o_cost) ≥ UTH.

## Operation
- Beat accepted when i_valid && o_ready. Beat counter 0..NB−1; wraps to 0 after the beat at NB−1 (last beat).
- Per beat: combinational lane tree yields (min, idx, second) over P lanes; merged with accumulator (best_c, best_d, sec_c). Beat 0 loads the accumulator instead of merging.
- Compare rule: candidate replaces best only if strictly smaller; ties keep the lower disparity. Second-best is the smallest of all costs not selected as best (duplicate minimum gives second == best).
- On last beat: merged result written into a single-entry output register, o_valid set; accumulator reloads on the next beat 0.
- o_ready = !o_valid || i_ready. Holds off all beats while the output register is full and not draining; a partially accumulated pixel simply pauses.
- Output held stable while o_valid && !i_ready.
- Arithmetic: unsigned costs; difference computed in CBIT bits (second ≥ best always, no underflow).

## Timing
- Reset values: o_valid 0, o_disp 0, o_cost 0, o_second 0, o_unique 0, beat counter 0, accumulator cleared.
- Latency: o_valid rises the cycle after the last beat is accepted.
- Throughput: one pixel per NB cycles with no stalls; last beat of pixel n+1 is accepted in the same cycle that result n is consumed.
- Reset mid-pixel: partial pixel discarded; the next accepted beat is beat 0 of a new pixel.
- Simultaneous last beat and result drain: new result replaces old in the same edge, o_valid stays 1.
- i_valid gaps between beats: accumulator and counter hold.

## Structure
- Shared package: DBIT/CBIT derivation functions, beat-counter width, a cost/disp pair typedef.
- One sub-module: disp_lane_min2, a combinational P-lane reduction returning min, min index and second minimum; instantiated once, reused for the accumulator merge as a 2-input case.

## Test plan
- D=64, P=4: cost 5 at d=37, 100 elsewhere, 16 back-to-back beats -> o_disp=37, o_cost=5, o_second=100, o_unique=1, o_valid one cycle after beat 15.
- Cost 3 at d=10 and d=50, 90 elsewhere -> o_disp=10, o_cost=3, o_second=3, o_unique=0; repeat with ties in one beat (d=8,9) -> o_disp=8.
- Cost 20 at d=0, 21 at d=63, 200 elsewhere, UTH=2 -> o_disp=0, o_second=21, o_unique=0.
- Two pixels back-to-back, i_ready low for 10 cycles -> result 1 held stable, o_ready low at pixel 2's last beat until i_ready rises, result 2 follows with no loss.
- Assert i_rst after 7 beats, then send a full pixel with min 7 at d=2 -> o_disp=2, o_cost=7; no output from the aborted pixel.
- All costs at 2**CBIT−1 with random i_valid gaps -> o_disp=0, o_cost=o_second=all ones, o_unique=0.

Source files
------------

// File: rtl/disp_wta_stream_pkg.sv
// Shared definitions for the streaming winner-takes-all disparity selector.
//
// Contents:
//   calc_dbit  - disparity index width for D candidates
//   calc_cbit  - matching-cost width for a census window WC x WC aggregated
//                over a WH x WH window
//   calc_nbit  - beat-counter width for NB beats per pixel
//   cost_disp_t - (cost, disparity) pair at the default configuration
package disp_wta_stream_pkg;

  // Width of a disparity index.
  // A single-candidate case still needs one bit so the port is never zero-width.
  function automatic int calc_dbit(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Width of an aggregated census cost.
  // A census window of WC x WC yields (WC*WC)/2 compared pairs per pixel.
  // Summing over a WH x WH aggregation window multiplies that by WH*WH.
  function automatic int calc_cbit(input int wc, input int wh);
    return $clog2(((wc ** 2) / 2) * (wh ** 2));
  endfunction

  // Width of the beat counter that walks 0..NB-1.
  function automatic int calc_nbit(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  localparam int DEF_DBIT = calc_dbit(64);
  localparam int DEF_CBIT = calc_cbit(3, 7);

  // Winning (cost, disparity) pair at the default configuration
  typedef struct packed {
    logic [DEF_CBIT-1:0] cost;
    logic [DEF_DBIT-1:0] disp;
  } cost_disp_t;

endpackage

// File: rtl/disp_wta_stream_lane_min2.sv
// disp_lane_min2: combinational N-lane reduction to (minimum, index of
// minimum, second minimum).
//
// Ports:
//   costs - N packed costs, lane k at bits k*CBIT +: CBIT
//   min_c - smallest cost
//   min_i - lane index of the smallest cost. On a tie this is the lowest lane.
//   sec_c - smallest cost among the lanes not chosen as minimum.
//           It equals min_c when the minimum is duplicated.
//
// Used once with N = P for the lanes of a beat. Used once with N = 2 to
// merge a beat into the running accumulator.
module disp_lane_min2 #(
  parameter int N    = 4,
  parameter int CBIT = 8,
  parameter int IBIT = 2
) (
  input  logic [N*CBIT-1:0] costs,
  output logic [CBIT-1:0]   min_c,
  output logic [IBIT-1:0]   min_i,
  output logic [CBIT-1:0]   sec_c
);

  // Single pass over the lanes.
  // A lane replaces the minimum only when it is strictly smaller, so the
  // lowest index wins ties. When a lane replaces the minimum, the old
  // minimum drops to second place. An equal lane falls through to the
  // second-place test, which is what makes a duplicated minimum report
  // second == best.
  always_comb begin
    min_c = costs[0 +: CBIT];
    min_i = '0;
    sec_c = '1;
    for (int k = 1; k < N; k++) begin
      if (costs[k*CBIT +: CBIT] < min_c) begin
        sec_c = min_c;
        min_c = costs[k*CBIT +: CBIT];
        min_i = IBIT'(k);
      end else if (costs[k*CBIT +: CBIT] < sec_c) begin
        sec_c = costs[k*CBIT +: CBIT];
      end
    end
  end

endmodule

// File: rtl/disp_wta_stream.sv
// disp_wta_stream: streaming winner-takes-all disparity selector.
//
// Each pixel arrives as NB = D/P beats of P costs. The block outputs the
// following for each pixel:
//   o_disp   - the best disparity
//   o_cost   - its cost
//   o_second - the second-smallest cost
//   o_unique - the uniqueness flag
//
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_valid/o_ready  - input beat handshake; i_cost carries P lanes per beat
//   o_valid/i_ready  - result handshake
//   o_disp, o_cost, o_second, o_unique - registered result
module disp_wta_stream
  import disp_wta_stream_pkg::*;
#(
  parameter  int WC   = 3,
  parameter  int WH   = 7,
  parameter  int D    = 64,
  parameter  int P    = 4,
  parameter  int UTH  = 2,
  localparam int DBIT = calc_dbit(D),
  localparam int CBIT = calc_cbit(WC, WH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [P*CBIT-1:0] i_cost,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DBIT-1:0]   o_disp,
  output logic [CBIT-1:0]   o_cost,
  output logic [CBIT-1:0]   o_second,
  output logic              o_unique
);

  localparam int NB   = D / P;
  localparam int NBIT = calc_nbit(NB);
  localparam int LBIT = calc_nbit(P);

  logic [NBIT-1:0] beat_cnt;
  logic            accept;
  logic            first_beat;
  logic            last_beat;

  // Lane reduction of the current beat
  logic [CBIT-1:0] lane_c;
  logic [LBIT-1:0] lane_i;
  logic [CBIT-1:0] lane_s;
  logic [DBIT-1:0] lane_d;

  // Running accumulator for the pixel in progress
  logic [CBIT-1:0] acc_c;
  logic [DBIT-1:0] acc_d;
  logic [CBIT-1:0] acc_s;

  // Accumulator merged with the current beat
  logic [CBIT-1:0] mrg_c;
  logic [0:0]      mrg_i;
  logic [CBIT-1:0] mrg_loser;
  logic [CBIT-1:0] mrg_s;

  // Value the accumulator/result takes on this beat
  logic [CBIT-1:0] cur_c;
  logic [DBIT-1:0] cur_d;
  logic [CBIT-1:0] cur_s;

  // A full output register blocks new beats unless it drains this cycle.
  // A partly accumulated pixel just pauses in that case.
  assign o_ready    = !o_valid || i_ready;
  assign accept     = i_valid && o_ready;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == NBIT'(NB - 1));

  disp_lane_min2 #(
    .N    (P),
    .CBIT (CBIT),
    .IBIT (LBIT)
  ) u_lane_min (
    .costs (i_cost),
    .min_c (lane_c),
    .min_i (lane_i),
    .sec_c (lane_s)
  );

  // Lane k of beat b holds disparity b*P + k
  assign lane_d = DBIT'(beat_cnt) * DBIT'(P) + DBIT'(lane_i);

  // Merge the accumulator (lane 0) with the beat winner (lane 1).
  // Earlier beats carry lower disparities, so putting the accumulator in
  // lane 0 makes ties keep the lower disparity.
  disp_lane_min2 #(
    .N    (2),
    .CBIT (CBIT),
    .IBIT (1)
  ) u_merge_min (
    .costs ({lane_c, acc_c}),
    .min_c (mrg_c),
    .min_i (mrg_i),
    .sec_c (mrg_loser)
  );

  // The pixel's second-best is the smallest of three candidates:
  //   - the merge loser
  //   - the accumulator's second-best
  //   - the beat's second-best
  // Beat 0 bypasses the merge so that stale accumulator contents from the
  // previous pixel never leak in.
  always_comb begin
    mrg_s = mrg_loser;
    if (acc_s < mrg_s) mrg_s = acc_s;
    if (lane_s < mrg_s) mrg_s = lane_s;
    if (first_beat) begin
      cur_c = lane_c;
      cur_d = lane_d;
      cur_s = lane_s;
    end else begin
      cur_c = mrg_c;
      cur_d = mrg_i[0] ? lane_d : acc_d;
      cur_s = mrg_s;
    end
  end

  // Beat counter and accumulator.
  // Both advance only on an accepted beat, so gaps in i_valid simply hold
  // state. The counter wraps after the last beat, and the next beat 0
  // reloads the accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt <= '0;
      acc_c    <= '0;
      acc_d    <= '0;
      acc_s    <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      acc_c    <= cur_c;
      acc_d    <= cur_d;
      acc_s    <= cur_s;
    end
  end

  // Single-entry result register.
  // A last beat loads a new result, even while the previous one drains in
  // the same edge, and o_valid stays high. Otherwise a drain clears
  // o_valid. The outputs are untouched while stalled.
  // Since second >= best always holds, the margin subtraction cannot
  // underflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_disp   <= '0;
      o_cost   <= '0;
      o_second <= '0;
      o_unique <= 1'b0;
    end else if (accept && last_beat) begin
      o_valid  <= 1'b1;
      o_disp   <= cur_d;
      o_cost   <= cur_c;
      o_second <= cur_s;
      o_unique <= ((cur_s - cur_c) >= CBIT'(UTH));
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_wta_stream.sv
// Directed testbench for disp_wta_stream at D=64, P=4, WC=3, WH=7, UTH=2
// (CBIT=8, DBIT=6, 16 beats per pixel).
// The driver pushes the hand-computed result of each full pixel into a
// scoreboard. The monitor pops and compares on every result handshake. It
// also checks that a stalled result stays stable.
module tb_disp_wta_stream;
  import disp_wta_stream_pkg::*;

  localparam int D    = 64;
  localparam int P    = 4;
  localparam int NB   = D / P;
  localparam int CBIT = DEF_CBIT;
  localparam int DBIT = DEF_DBIT;

  typedef struct {
    cost_disp_t      best;
    logic [CBIT-1:0] second;
    logic            uniq;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [P*CBIT-1:0] i_cost;
  logic              o_valid;
  logic              i_ready;
  logic [DBIT-1:0]   o_disp;
  logic [CBIT-1:0]   o_cost;
  logic [CBIT-1:0]   o_second;
  logic              o_unique;

  exp_t sb_q[$];
  int   cost_vec[D];
  int   tests_run    = 0;
  int   tests_failed = 0;

  disp_wta_stream #(
    .WC  (3),
    .WH  (7),
    .D   (D),
    .P   (P),
    .UTH (2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_cost   (i_cost),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_disp   (o_disp),
    .o_cost   (o_cost),
    .o_second (o_second),
    .o_unique (o_unique)
  );

  always #5 i_clk = ~i_clk;

  // Counted comparison with a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input int d, input int c, input int s, input bit u);
    exp_t e;
    e.best.disp = DBIT'(d);
    e.best.cost = CBIT'(c);
    e.second    = CBIT'(s);
    e.uniq      = u;
    return e;
  endfunction

  task automatic fillCosts(input int value);
    for (int i = 0; i < D; i++) cost_vec[i] = value;
  endtask

  // Drive nbeats beats of cost_vec.
  // Only a full pixel pushes an expected result. With gaps set, random
  // idle cycles go between beats. With chk_lat set, the bench checks that
  // o_valid is low before the last beat and high right after it.
  task automatic applyStimulus(input int nbeats, input bit gaps, input bit chk_lat,
                               input exp_t e);
    bit accepted;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        i_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge i_clk);
          #1;
        end
      end
      for (int k = 0; k < P; k++) i_cost[k*CBIT +: CBIT] = CBIT'(cost_vec[b*P + k]);
      i_valid = 1'b1;
      if (b == NB - 1) sb_q.push_back(e);
      accepted = 1'b0;
      for (int t = 0; t < 300 && !accepted; t++) begin
        @(negedge i_clk);
        if (chk_lat && b == NB - 1 && t == 0) checkOutput("valid_before_last", 32'(o_valid), 0);
        accepted = o_ready;
        @(posedge i_clk);
        #1;
      end
      if (!accepted) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL beat_timeout: beat %0d not accepted, required acceptance", b);
        i_valid = 1'b0;
        return;
      end
    end
    i_valid = 1'b0;
    if (chk_lat) checkOutput("latency_valid", 32'(o_valid), 1);
  endtask

  // Monitor: pops the scoreboard on each result handshake.
  // While a result is stalled it checks the register holds steady and
  // that the block refuses beats.
  logic            held;
  logic [DBIT-1:0] held_d;
  logic [CBIT-1:0] held_c;
  logic [CBIT-1:0] held_s;
  logic            held_u;

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("hold_valid",  32'(o_valid),  1);
        checkOutput("hold_disp",   32'(o_disp),   32'(held_d));
        checkOutput("hold_cost",   32'(o_cost),   32'(held_c));
        checkOutput("hold_second", 32'(o_second), 32'(held_s));
        checkOutput("hold_unique", 32'(o_unique), 32'(held_u));
      end
      if (o_valid && !i_ready) begin
        checkOutput("ready_low_when_full", 32'(o_ready), 0);
        held   = 1'b1;
        held_d = o_disp;
        held_c = o_cost;
        held_s = o_second;
        held_u = o_unique;
      end else begin
        held = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_result: got disp %0d cost %0d, expected no result",
                   o_disp, o_cost);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result_disp",   32'(o_disp),   32'(e.best.disp));
          checkOutput("result_cost",   32'(o_cost),   32'(e.best.cost));
          checkOutput("result_second", 32'(o_second), 32'(e.second));
          checkOutput("result_unique", 32'(o_unique), 32'(e.uniq));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_cost  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_valid",  32'(o_valid),  0);
    checkOutput("reset_disp",   32'(o_disp),   0);
    checkOutput("reset_cost",   32'(o_cost),   0);
    checkOutput("reset_second", 32'(o_second), 0);
    checkOutput("reset_unique", 32'(o_unique), 0);
    checkOutput("reset_ready",  32'(o_ready),  1);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    $display("[TB] single minimum at d=37");
    fillCosts(100); cost_vec[37] = 5;
    applyStimulus(NB, 1'b0, 1'b1, mkExp(37, 5, 100, 1'b1));
    repeat (3) @(posedge i_clk);
    #1;

    $display("[TB] duplicate minimum in different beats");
    fillCosts(90); cost_vec[10] = 3; cost_vec[50] = 3;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(10, 3, 3, 1'b0));

    $display("[TB] duplicate minimum inside one beat");
    fillCosts(90); cost_vec[8] = 3; cost_vec[9] = 3;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(8, 3, 3, 1'b0));

    $display("[TB] margin below threshold across first and last disparity");
    fillCosts(200); cost_vec[0] = 20; cost_vec[63] = 21;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(0, 20, 21, 1'b0));

    $display("[TB] margin equal to threshold inside one beat");
    fillCosts(99); cost_vec[3] = 50; cost_vec[2] = 52;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(3, 50, 52, 1'b1));

    $display("[TB] minimum in the last beat");
    fillCosts(40); cost_vec[62] = 10; cost_vec[5] = 12;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(62, 10, 12, 1'b1));
    repeat (3) @(posedge i_clk);
    #1;

    $display("[TB] back-to-back pixels with downstream stall");
    i_ready = 1'b0;
    fork
      begin
        fillCosts(60); cost_vec[20] = 15;
        applyStimulus(NB, 1'b0, 1'b0, mkExp(20, 15, 60, 1'b1));
        fillCosts(70); cost_vec[45] = 69;
        applyStimulus(NB, 1'b0, 1'b0, mkExp(45, 69, 70, 1'b0));
      end
      begin
        for (int t = 0; t < 200 && !o_valid; t++) @(posedge i_clk);
        repeat (10) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    repeat (5) @(posedge i_clk);
    #1;

    $display("[TB] reset in the middle of a pixel");
    fillCosts(1);
    applyStimulus(7, 1'b0, 1'b0, mkExp(0, 0, 0, 1'b0));
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_mid_valid", 32'(o_valid), 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    fillCosts(100); cost_vec[2] = 7;
    applyStimulus(NB, 1'b0, 1'b0, mkExp(2, 7, 100, 1'b1));
    repeat (3) @(posedge i_clk);
    #1;

    $display("[TB] all costs at maximum with input gaps");
    fillCosts(255);
    applyStimulus(NB, 1'b1, 1'b0, mkExp(0, 255, 255, 1'b0));

    repeat (20) @(posedge i_clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
